// File: rtl/sdram_responder.sv
`default_nettype none
// ============================================================================
// sdram_responder : cycle-accurate SDR SDRAM device model, 4 banks, 32-bit DQ
// Rev 1.0 : initial release
// ============================================================================
module sdram_responder #(
    parameter int MEM_AW = 12
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [10:0] sdram_addr,
    input  logic [1:0]  sdram_ba,
    input  logic        sdram_ras_n,
    input  logic        sdram_cas_n,
    input  logic        sdram_we_n,
    input  logic [31:0] sdram_dq_i,
    output logic [31:0] sdram_dq_o,
    output logic        sdram_dq_oe,
    output logic        cmd_err,
    output logic [15:0] ref_count
);

    localparam logic [2:0] CMD_ACT   = 3'b011;
    localparam logic [2:0] CMD_READ  = 3'b101;
    localparam logic [2:0] CMD_WRITE = 3'b100;
    localparam logic [2:0] CMD_PRE   = 3'b010;
    localparam logic [2:0] CMD_REF   = 3'b001;
    localparam logic [2:0] CMD_MRS   = 3'b000;
    localparam logic [2:0] CMD_BST   = 3'b110;

    typedef struct packed {
        logic        vld;
        logic [1:0]  ba;
        logic [10:0] row;
        logic [7:0]  col;
        logic [2:0]  mask;
        logic        ap;
    } burst_t;

    logic [31:0] mem [2**MEM_AW];

    logic [3:0]  bank_act;
    logic [10:0] bank_row [4];
    logic [2:0]  bl_mask;
    logic        cl3;

    burst_t      pipe [2];
    burst_t      rd_cur;
    logic [2:0]  rd_cnt;
    burst_t      wr_cur;
    logic [2:0]  wr_cnt;

    logic [2:0]        cmd;
    logic              tgt_act;
    logic              rd_ok;
    logic              wr_ok;
    logic              rd_break;
    logic              wr_stop;
    burst_t            new_burst;
    burst_t            rd_src;
    logic [2:0]        rd_beat;
    logic              rd_issue;
    logic              rd_last;
    logic [MEM_AW-1:0] rd_idx;
    burst_t            wr_src;
    logic [2:0]        wr_beat;
    logic              wr_last;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_idx;

    // Sequential beat order wraps inside the BL-aligned column block.
    function automatic logic [7:0] beat_col(input logic [7:0] col, input logic [2:0] mask,
                                            input logic [2:0] beat);
        logic [7:0] m;
        m = {5'd0, mask};
        return (col & ~m) | ((col + {5'd0, beat}) & m);
    endfunction

    function automatic logic [MEM_AW-1:0] word_idx(input logic [1:0] ba, input logic [10:0] row,
                                                   input logic [7:0] col);
        return {ba, (MEM_AW-2)'({row, col})};
    endfunction

    always_comb begin
        cmd      = {sdram_ras_n, sdram_cas_n, sdram_we_n};
        tgt_act  = bank_act[sdram_ba];
        rd_ok    = (cmd == CMD_READ) && tgt_act;
        wr_ok    = (cmd == CMD_WRITE) && tgt_act;
        rd_break = wr_ok || (cmd == CMD_BST);
        wr_stop  = rd_ok || wr_ok || (cmd == CMD_BST);

        new_burst.vld  = 1'b1;
        new_burst.ba   = sdram_ba;
        new_burst.row  = bank_row[sdram_ba];
        new_burst.col  = sdram_addr[7:0];
        new_burst.mask = bl_mask;
        new_burst.ap   = sdram_addr[10];

        // A read leaving the latency pipe pre-empts whatever burst is still draining.
        rd_src   = pipe[0].vld ? pipe[0] : rd_cur;
        rd_beat  = pipe[0].vld ? 3'd0 : rd_cnt;
        rd_issue = (pipe[0].vld || rd_cur.vld) && !rd_break;
        rd_last  = (rd_beat == rd_src.mask);
        rd_idx   = word_idx(rd_src.ba, rd_src.row, beat_col(rd_src.col, rd_src.mask, rd_beat));

        wr_src   = wr_ok ? new_burst : wr_cur;
        wr_beat  = wr_ok ? 3'd0 : wr_cnt;
        wr_last  = (wr_beat == wr_src.mask);
        mem_we   = resetn && (wr_ok || (wr_cur.vld && !wr_stop));
        mem_idx  = word_idx(wr_src.ba, wr_src.row, beat_col(wr_src.col, wr_src.mask, wr_beat));
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= sdram_dq_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bank_act    <= '0;
            for (int b = 0; b < 4; b++) begin
                bank_row[b] <= '0;
            end
            bl_mask     <= 3'd0;
            cl3         <= 1'b0;
            pipe[0]     <= '0;
            pipe[1]     <= '0;
            rd_cur      <= '0;
            rd_cnt      <= 3'd0;
            wr_cur      <= '0;
            wr_cnt      <= 3'd0;
            sdram_dq_oe <= 1'b0;
            sdram_dq_o  <= '0;
            cmd_err     <= 1'b0;
            ref_count   <= '0;
        end else begin
            pipe[0] <= pipe[1];
            pipe[1] <= '0;
            if (rd_ok) begin
                if (cl3) begin
                    pipe[1] <= new_burst;
                end else begin
                    pipe[0] <= new_burst;
                end
            end
            if (rd_break) begin
                pipe[0] <= '0;
                pipe[1] <= '0;
            end

            sdram_dq_oe <= rd_issue;
            sdram_dq_o  <= rd_issue ? mem[rd_idx] : '0;
            if (rd_issue) begin
                rd_cur     <= rd_src;
                rd_cur.vld <= !rd_last;
                rd_cnt     <= rd_beat + 3'd1;
                if (rd_last && rd_src.ap) begin
                    bank_act[rd_src.ba] <= 1'b0;
                end
            end else begin
                rd_cur.vld <= 1'b0;
            end

            if (mem_we) begin
                wr_cur     <= wr_src;
                wr_cur.vld <= !wr_last;
                wr_cnt     <= wr_beat + 3'd1;
                if (wr_last && wr_src.ap) begin
                    bank_act[wr_src.ba] <= 1'b0;
                end
            end else begin
                wr_cur.vld <= 1'b0;
            end

            case (cmd)
                CMD_ACT: begin
                    if (tgt_act) begin
                        cmd_err <= 1'b1;
                    end else begin
                        bank_act[sdram_ba] <= 1'b1;
                        bank_row[sdram_ba] <= sdram_addr;
                    end
                end
                CMD_READ, CMD_WRITE: begin
                    if (!tgt_act) begin
                        cmd_err <= 1'b1;
                    end
                end
                CMD_PRE: begin
                    if (sdram_addr[10]) begin
                        bank_act <= '0;
                    end else begin
                        bank_act[sdram_ba] <= 1'b0;
                    end
                end
                CMD_REF: begin
                    if (|bank_act) begin
                        cmd_err <= 1'b1;
                    end else begin
                        ref_count <= ref_count + 16'd1;
                    end
                end
                CMD_MRS: begin
                    // Legal BL codes are 0..3 (addr[2]=0); legal CL codes are 2 and 3.
                    if ((|bank_act) || sdram_addr[2] || (sdram_addr[6:5] != 2'b01)) begin
                        cmd_err <= 1'b1;
                    end else begin
                        bl_mask <= 3'((4'd1 << sdram_addr[1:0]) - 4'd1);
                        cl3     <= sdram_addr[4];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_responder.sv
`default_nettype none
// ============================================================================
// tb_sdram_responder : vector table for command/flag behaviour plus a beat
// scoreboard for read timing and data.   Rev 1.0
// ============================================================================
module tb_sdram_responder;

    localparam logic [2:0] NOP   = 3'b111;
    localparam logic [2:0] ACT   = 3'b011;
    localparam logic [2:0] READ  = 3'b101;
    localparam logic [2:0] WRITE = 3'b100;
    localparam logic [2:0] PRE   = 3'b010;
    localparam logic [2:0] REF   = 3'b001;
    localparam logic [2:0] MRS   = 3'b000;
    localparam logic [2:0] BST   = 3'b110;

    logic        clk;
    logic        resetn;
    logic [10:0] sdram_addr;
    logic [1:0]  sdram_ba;
    logic        sdram_ras_n;
    logic        sdram_cas_n;
    logic        sdram_we_n;
    logic [31:0] sdram_dq_i;
    logic [31:0] sdram_dq_o;
    logic        sdram_dq_oe;
    logic        cmd_err;
    logic [15:0] ref_count;

    sdram_responder #(.MEM_AW(12)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .sdram_addr  (sdram_addr),
        .sdram_ba    (sdram_ba),
        .sdram_ras_n (sdram_ras_n),
        .sdram_cas_n (sdram_cas_n),
        .sdram_we_n  (sdram_we_n),
        .sdram_dq_i  (sdram_dq_i),
        .sdram_dq_o  (sdram_dq_o),
        .sdram_dq_oe (sdram_dq_oe),
        .cmd_err     (cmd_err),
        .ref_count   (ref_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int drv_cyc  = 0;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic        rst;
        logic [2:0]  c;
        logic [1:0]  ba;
        logic [10:0] a;
        logic        exp_err;
        logic [15:0] exp_ref;
    } vec_t;
    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic issue(input logic [2:0] c, input logic [1:0] ba, input logic [10:0] a,
                         input logic [31:0] d);
        @(negedge clk);
        {sdram_ras_n, sdram_cas_n, sdram_we_n} = c;
        sdram_ba   = ba;
        sdram_addr = a;
        sdram_dq_i = d;
        drv_cyc    = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(NOP, 2'd0, 11'd0, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        {sdram_ras_n, sdram_cas_n, sdram_we_n} = NOP;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic expect_beat(input int c, input logic [31:0] d);
        exp_t e;
        e.cyc  = c;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Every read beat must match the head of the scoreboard; the idle bus must be zero.
    always @(negedge clk) begin
        exp_t e;
        if (sdram_dq_oe === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_beat: dq_oe=1 data %h at cycle %0d, none expected",
                         sdram_dq_o, cyc);
            end else begin
                e = exp_q.pop_front();
                check("beat_cycle", cyc, e.cyc);
                check("beat_data", sdram_dq_o, e.data);
            end
        end else begin
            check("idle_dq_zero", sdram_dq_o, 32'd0);
            if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                n_checks++;
                $display("FAIL missing_beat: dq_oe=0 at cycle %0d, expected beat %h at cycle %0d",
                         cyc, e.data, e.cyc);
            end
        end
    end

    logic [7:0] ord8 [8];

    initial begin
        resetn = 1'b0;
        {sdram_ras_n, sdram_cas_n, sdram_we_n} = NOP;
        sdram_ba   = '0;
        sdram_addr = '0;
        sdram_dq_i = '0;
        ord8 = '{8'd6, 8'd7, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};

        //          rst   cmd    ba    addr     err   ref
        vecs[0]  = '{1'b1, NOP,   2'd0, 11'h000, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, REF,   2'd0, 11'h000, 1'b0, 16'd1};
        vecs[2]  = '{1'b0, REF,   2'd0, 11'h000, 1'b0, 16'd2};
        vecs[3]  = '{1'b0, REF,   2'd0, 11'h000, 1'b0, 16'd3};
        vecs[4]  = '{1'b0, ACT,   2'd0, 11'h005, 1'b0, 16'd3};
        vecs[5]  = '{1'b0, REF,   2'd0, 11'h000, 1'b1, 16'd3};
        vecs[6]  = '{1'b1, ACT,   2'd0, 11'h005, 1'b0, 16'd0};
        vecs[7]  = '{1'b0, ACT,   2'd0, 11'h009, 1'b1, 16'd0};
        vecs[8]  = '{1'b1, MRS,   2'd0, 11'h025, 1'b1, 16'd0};
        vecs[9]  = '{1'b1, MRS,   2'd0, 11'h042, 1'b1, 16'd0};
        vecs[10] = '{1'b1, ACT,   2'd2, 11'h001, 1'b0, 16'd0};
        vecs[11] = '{1'b0, MRS,   2'd0, 11'h022, 1'b1, 16'd0};
        vecs[12] = '{1'b1, PRE,   2'd3, 11'h000, 1'b0, 16'd0};
        vecs[13] = '{1'b1, READ,  2'd2, 11'h010, 1'b1, 16'd0};
        vecs[14] = '{1'b1, WRITE, 2'd1, 11'h010, 1'b1, 16'd0};
        vecs[15] = '{1'b1, BST,   2'd0, 11'h000, 1'b0, 16'd0};

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].rst) do_reset();
            issue(vecs[i].c, vecs[i].ba, vecs[i].a, 32'h0);
            issue(NOP, 2'd0, 11'd0, 32'd0);
            check($sformatf("vec%0d_err", i), cmd_err, vecs[i].exp_err);
            check($sformatf("vec%0d_ref", i), ref_count, vecs[i].exp_ref);
            check($sformatf("vec%0d_oe", i), sdram_dq_oe, 1'b0);
        end
        idle(4);

        // CL2/BL4 write then read, and wrapped read starting mid-block
        do_reset();
        issue(MRS, 2'd0, 11'h022, 32'd0);
        issue(ACT, 2'd1, 11'd3, 32'd0);
        issue(WRITE, 2'd1, 11'h010, 32'hA0);
        issue(NOP, 2'd0, 11'd0, 32'hA1);
        issue(NOP, 2'd0, 11'd0, 32'hA2);
        issue(NOP, 2'd0, 11'd0, 32'hA3);
        issue(NOP, 2'd0, 11'd0, 32'h0);
        issue(READ, 2'd1, 11'h010, 32'd0);
        for (int i = 0; i < 4; i++) expect_beat(drv_cyc + 2 + i, 32'hA0 + i);
        idle(6);
        issue(READ, 2'd1, 11'h012, 32'd0);
        expect_beat(drv_cyc + 2, 32'hA2);
        expect_beat(drv_cyc + 3, 32'hA3);
        expect_beat(drv_cyc + 4, 32'hA0);
        expect_beat(drv_cyc + 5, 32'hA1);
        idle(6);

        // Second READ two cycles later takes over the bus from the first
        issue(READ, 2'd1, 11'h010, 32'd0);
        expect_beat(drv_cyc + 2, 32'hA0);
        expect_beat(drv_cyc + 3, 32'hA1);
        issue(NOP, 2'd0, 11'd0, 32'd0);
        issue(READ, 2'd1, 11'h012, 32'd0);
        expect_beat(drv_cyc + 2, 32'hA2);
        expect_beat(drv_cyc + 3, 32'hA3);
        expect_beat(drv_cyc + 4, 32'hA0);
        expect_beat(drv_cyc + 5, 32'hA1);
        idle(7);

        // Write burst cut by BST keeps only beat 0
        issue(WRITE, 2'd1, 11'h020, 32'hE0);
        issue(NOP, 2'd0, 11'd0, 32'hE1);
        issue(NOP, 2'd0, 11'd0, 32'hE2);
        issue(NOP, 2'd0, 11'd0, 32'hE3);
        issue(WRITE, 2'd1, 11'h020, 32'hF0);
        issue(BST, 2'd0, 11'd0, 32'hF1);
        issue(NOP, 2'd0, 11'd0, 32'hF2);
        issue(NOP, 2'd0, 11'd0, 32'hF3);
        issue(READ, 2'd1, 11'h020, 32'd0);
        expect_beat(drv_cyc + 2, 32'hF0);
        expect_beat(drv_cyc + 3, 32'hE1);
        expect_beat(drv_cyc + 4, 32'hE2);
        expect_beat(drv_cyc + 5, 32'hE3);
        idle(6);
        check("seqA_err", cmd_err, 1'b0);

        // CL3/BL8 with wrap from column 6
        issue(PRE, 2'd0, 11'h400, 32'd0);
        issue(MRS, 2'd0, 11'h033, 32'd0);
        issue(ACT, 2'd1, 11'd3, 32'd0);
        issue(WRITE, 2'd1, 11'h000, 32'hB0);
        for (int i = 1; i < 8; i++) issue(NOP, 2'd0, 11'd0, 32'hB0 + i);
        issue(NOP, 2'd0, 11'd0, 32'd0);
        issue(READ, 2'd1, 11'h006, 32'd0);
        for (int i = 0; i < 8; i++) expect_beat(drv_cyc + 3 + i, 32'hB0 + 32'(ord8[i]));
        idle(12);

        // Illegal MRS flags an error and leaves CL3/BL8 in force
        issue(PRE, 2'd0, 11'h400, 32'd0);
        issue(MRS, 2'd0, 11'h042, 32'd0);
        issue(NOP, 2'd0, 11'd0, 32'd0);
        check("bad_mrs_err", cmd_err, 1'b1);
        issue(ACT, 2'd1, 11'd3, 32'd0);
        issue(READ, 2'd1, 11'h000, 32'd0);
        for (int i = 0; i < 8; i++) expect_beat(drv_cyc + 3 + i, 32'hB0 + i);
        idle(12);

        // BST right after the first beat leaves exactly one beat
        issue(PRE, 2'd0, 11'h400, 32'd0);
        issue(MRS, 2'd0, 11'h022, 32'd0);
        issue(ACT, 2'd1, 11'd3, 32'd0);
        issue(READ, 2'd1, 11'h000, 32'd0);
        expect_beat(drv_cyc + 2, 32'hB0);
        issue(NOP, 2'd0, 11'd0, 32'd0);
        issue(BST, 2'd0, 11'd0, 32'd0);
        idle(6);

        // Auto-precharge write closes the bank; following READ is an error
        do_reset();
        issue(ACT, 2'd0, 11'd0, 32'd0);
        issue(WRITE, 2'd0, 11'h405, 32'h55);
        issue(NOP, 2'd0, 11'd0, 32'd0);
        check("ap_pre_err", cmd_err, 1'b0);
        issue(READ, 2'd0, 11'h005, 32'd0);
        issue(NOP, 2'd0, 11'd0, 32'd0);
        check("ap_read_err", cmd_err, 1'b1);
        idle(4);

        // Rejected second ACT must not move the open row
        do_reset();
        issue(ACT, 2'd0, 11'd1, 32'd0);
        issue(WRITE, 2'd0, 11'h000, 32'h77);
        issue(PRE, 2'd0, 11'h000, 32'd0);
        issue(ACT, 2'd0, 11'd1, 32'd0);
        issue(ACT, 2'd0, 11'd2, 32'd0);
        issue(READ, 2'd0, 11'h000, 32'd0);
        expect_beat(drv_cyc + 2, 32'h77);
        issue(NOP, 2'd0, 11'd0, 32'd0);
        check("dup_act_err", cmd_err, 1'b1);
        idle(4);

        // Reset during an 8-beat read, then BL1/CL2 defaults and retained data
        do_reset();
        issue(MRS, 2'd0, 11'h033, 32'd0);
        issue(ACT, 2'd1, 11'd3, 32'd0);
        issue(READ, 2'd1, 11'h000, 32'd0);
        for (int i = 0; i < 3; i++) expect_beat(drv_cyc + 3 + i, 32'hB0 + i);
        idle(5);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        check("rst_err", cmd_err, 1'b0);
        issue(ACT, 2'd1, 11'd3, 32'd0);
        issue(READ, 2'd1, 11'h011, 32'd0);
        expect_beat(drv_cyc + 2, 32'hA1);
        idle(6);

        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d beats outstanding, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
